alu_op_scheduler: RTL



---
 rtl/alu_op_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - two-requester round-robin scheduler in front of a shared 4-bit ALU
//
// Optional feature macro: ALU_OP_COUNT_EN
//   defined   : cnt0/cnt1 count completed response handshakes per requester (8-bit, wrapping)
//   undefined : cnt0/cnt1 are tied to 0 and no counter flops exist
//
// Flow: IDLE grants one requester (round-robin on contention) and latches its operands,
// EXEC holds operands and the one-hot select on the ALU for ALU_LATENCY cycles and then
// captures the result, RESP presents the result to the granted requester until it is taken.
// Only one operation is ever in flight.

module alu_op_scheduler #(
    parameter int ALU_LATENCY = 1   // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_op,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_op,

    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [7:0] alu_sel,
    input  logic [7:0] alu_result,

    output logic       rsp0_valid,
    input  logic       rsp0_ready,
    output logic [7:0] rsp0_data,

    output logic       rsp1_valid,
    input  logic       rsp1_ready,
    output logic [7:0] rsp1_data,

    output logic       busy,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // The EXEC down-counter starts here so that EXEC lasts exactly ALU_LATENCY cycles.
    localparam logic [3:0] LAT_LOAD = 4'(ALU_LATENCY - 1);

    logic [1:0] state;
    logic       rr_last;     // id of the requester whose response completed last
    logic       gnt_id;      // id of the requester owning the in-flight op
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [2:0] op_q;
    logic [3:0] lat_cnt;
    logic [7:0] result_q;

    logic       grant0;
    logic       grant1;
    logic       in_idle;
    logic       in_exec;
    logic       in_resp;
    logic       accept;
    logic       rsp0_fire;
    logic       rsp1_fire;
    logic       rsp_fire;

    assign in_idle = (state == S_IDLE);
    assign in_exec = (state == S_EXEC);
    assign in_resp = (state == S_RESP);

    // Round-robin pick: a lone valid wins outright, on contention the requester not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = rr_last;
            grant1 = ~rr_last;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = in_idle & grant0;
    assign req1_ready = in_idle & grant1;
    assign accept     = req0_ready | req1_ready;

    // The ALU only sees live operands while an op is executing; otherwise it is parked at zero.
    assign alu_a   = in_exec ? a_q : 4'd0;
    assign alu_b   = in_exec ? b_q : 4'd0;
    assign alu_sel = in_exec ? (8'h80 >> op_q) : 8'd0;

    assign rsp0_valid = in_resp & ~gnt_id;
    assign rsp1_valid = in_resp &  gnt_id;
    assign rsp0_data  = rsp0_valid ? result_q : 8'd0;
    assign rsp1_data  = rsp1_valid ? result_q : 8'd0;

    assign rsp0_fire = rsp0_valid & rsp0_ready;
    assign rsp1_fire = rsp1_valid & rsp1_ready;
    assign rsp_fire  = rsp0_fire | rsp1_fire;

    assign busy = ~in_idle;

    // Sequencer: accept -> hold on ALU for ALU_LATENCY cycles -> present result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            rr_last  <= 1'b1;
            gnt_id   <= 1'b0;
            a_q      <= 4'd0;
            b_q      <= 4'd0;
            op_q     <= 3'd0;
            lat_cnt  <= 4'd0;
            result_q <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        gnt_id  <= req1_ready;
                        a_q     <= req1_ready ? req1_a  : req0_a;
                        b_q     <= req1_ready ? req1_b  : req0_b;
                        op_q    <= req1_ready ? req1_op : req0_op;
                        lat_cnt <= LAT_LOAD;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (lat_cnt == 4'd0) begin
                        result_q <= alu_result;
                        state    <= S_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_fire) begin
                        rr_last <= gnt_id;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ALU_OP_COUNT_EN
    logic [7:0] cnt0_q;
    logic [7:0] cnt1_q;

    // Per-requester completion counters, stepped on each response handshake and wrapping at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= 8'd0;
            cnt1_q <= 8'd0;
        end else begin
            if (rsp0_fire) begin
                cnt0_q <= cnt0_q + 8'd1;
            end
            if (rsp1_fire) begin
                cnt1_q <= cnt1_q + 8'd1;
            end
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    assign cnt0 = 8'd0;
    assign cnt1 = 8'd0;
`endif

endmodule
